// File: rtl/rr_fifo_arbiter_if.sv
// rr_fifo_arbiter_if: groups the requester-side and FIFO-side signals of
// the round-robin FIFO arbiter. The arbiter connects through the slave
// modport. The requesters, FIFO and return path (or a testbench) connect
// through the master modport.
interface rr_fifo_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_write;
  logic [32*NUM_REQ-1:0] req_addr;
  logic [32*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ack;
  logic [31:0]           req_rdata;
  logic [NUM_REQ-1:0]    req_rdata_ack;
  logic [NUM_REQ-1:0]    req_slverr;
  logic                  push_out;
  logic                  fifo_write_out;
  logic [31:0]           push_addr_out;
  logic [31:0]           push_wdata_out;
  logic                  full_i;
  logic [31:0]           rdata_in;
  logic                  rdata_valid_in;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, full_i, rdata_in, rdata_valid_in,
    output req_ack, req_rdata, req_rdata_ack, req_slverr,
    output push_out, fifo_write_out, push_addr_out, push_wdata_out
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, full_i, rdata_in, rdata_valid_in,
    input  req_ack, req_rdata, req_rdata_ack, req_slverr,
    input  push_out, fifo_write_out, push_addr_out, push_wdata_out
  );
endinterface

// File: rtl/rr_fifo_arbiter.sv
// rr_fifo_arbiter: round-robin arbiter that shares one FIFO push port among
// NUM_REQ requesters. Each transfer is granted in IDLE and pushed in ISSUE.
// A read then waits in WAIT_RD for its return data.
// Optional feature macro RR_TIMEOUT_EN adds a read-wait timeout. When the
// timeout fires, the read is answered with slverr=1 after TIMEOUT_CYC
// cycles in WAIT_RD.
module rr_fifo_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input logic               PCLK,
  input logic               PRESET,
  rr_fifo_arbiter_if.slave  bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT_RD = 2'd2;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [PW-1:0] PTR_RST = PW'(NUM_REQ - 1);

  logic [1:0]          state;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       gnt;
  logic                lat_write;
  logic [PW-1:0]       win;
  logic                found;
  logic [PW-1:0]       idx;
  logic                push_q;
  logic                fifo_write_q;
  logic [31:0]         push_addr_q;
  logic [31:0]         push_wdata_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [31:0]         rdata_q;
  logic [NUM_REQ-1:0]  rdata_ack_q;

`ifdef RR_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CW-1:0]       wait_cnt;
  logic [NUM_REQ-1:0]  slverr_q;
  assign bus.req_slverr = slverr_q;
`else
  assign bus.req_slverr = '0;
`endif

  assign bus.push_out       = push_q;
  assign bus.fifo_write_out = fifo_write_q;
  assign bus.push_addr_out  = push_addr_q;
  assign bus.push_wdata_out = push_wdata_q;
  assign bus.req_ack        = ack_q;
  assign bus.req_rdata      = rdata_q;
  assign bus.req_rdata_ack  = rdata_ack_q;

  // Pick the first valid requester after the last owner, wrapping around.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Arbitration FSM. All outputs are registered, and pulses clear every cycle by default.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state        <= ST_IDLE;
      ptr          <= PTR_RST;
      gnt          <= '0;
      lat_write    <= 1'b0;
      push_q       <= 1'b0;
      fifo_write_q <= 1'b0;
      push_addr_q  <= '0;
      push_wdata_q <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      rdata_ack_q  <= '0;
`ifdef RR_TIMEOUT_EN
      wait_cnt     <= '0;
      slverr_q     <= '0;
`endif
    end else begin
      push_q       <= 1'b0;
      fifo_write_q <= 1'b0;
      push_addr_q  <= '0;
      push_wdata_q <= '0;
      ack_q        <= '0;
      rdata_ack_q  <= '0;
`ifdef RR_TIMEOUT_EN
      slverr_q     <= '0;
`endif
      case (state)
        ST_IDLE: begin
          if (found && !bus.full_i) begin
            gnt          <= win;
            lat_write    <= bus.req_write[win];
            push_q       <= 1'b1;
            fifo_write_q <= bus.req_write[win];
            push_addr_q  <= bus.req_addr[win*32 +: 32];
            push_wdata_q <= bus.req_wdata[win*32 +: 32];
            ack_q        <= ONE_HOT0 << win;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          ptr   <= gnt;
          state <= lat_write ? ST_IDLE : ST_WAIT_RD;
`ifdef RR_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_WAIT_RD: begin
          if (bus.rdata_valid_in) begin
            rdata_q     <= bus.rdata_in;
            rdata_ack_q <= ONE_HOT0 << gnt;
            state       <= ST_IDLE;
`ifdef RR_TIMEOUT_EN
          end else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
            rdata_q     <= '0;
            rdata_ack_q <= ONE_HOT0 << gnt;
            slverr_q    <= ONE_HOT0 << gnt;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// tb_rr_fifo_arbiter: directed bench for rr_fifo_arbiter covering reset,
// round-robin order, write push fields, read return with a blocked
// requester, FIFO-full stall and reset during WAIT_RD. The read-wait
// timeout scenarios are included when RR_TIMEOUT_EN is defined.
module tb_rr_fifo_arbiter;
  localparam int N = 4;

  logic PCLK = 1'b0;
  logic PRESET;
  int   passed = 0;
  int   total  = 0;

  rr_fifo_arbiter_if #(.NUM_REQ(N)) bus ();

  rr_fifo_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(256)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus.slave)
  );

  // Free-running 10-unit clock.
  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    bus.req_valid = '0; bus.req_write = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus.full_i = 1'b0; bus.rdata_in = '0; bus.rdata_valid_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[32*i +: 32]  = 32'h100 + 32'(i);
      bus.req_wdata[32*i +: 32] = 32'hD000_0000 + 32'(i);
    end
    repeat (3) step();
    PRESET = 1'b0;
    total++;
    if ({bus.req_ack, bus.req_rdata_ack, bus.req_slverr, bus.push_out, bus.fifo_write_out} !== 14'd0)
      $display("[TB] FAIL reset_pulses got=%b want=0",
               {bus.req_ack, bus.req_rdata_ack, bus.req_slverr, bus.push_out, bus.fifo_write_out});
    else passed++;
    total++;
    if ({bus.push_addr_out, bus.push_wdata_out} !== 64'd0)
      $display("[TB] FAIL reset_push_bus got=%h want=0", {bus.push_addr_out, bus.push_wdata_out});
    else passed++;
    total++;
    if (bus.req_rdata !== 32'd0)
      $display("[TB] FAIL reset_rdata got=%h want=0", bus.req_rdata);
    else passed++;
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] e;
    bus.req_valid = 4'b1111;
    bus.req_write = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e = 4'(1) << order[k];
      step();
      total++;
      if (bus.req_ack !== e || bus.push_out !== 1'b1 || bus.fifo_write_out !== 1'b1 ||
          bus.push_addr_out !== 32'h100 + 32'(order[k]))
        $display("[TB] FAIL rr_grant%0d got ack=%b push=%b addr=%h want ack=%b push=1 addr=%h",
                 k, bus.req_ack, bus.push_out, bus.push_addr_out, e, 32'h100 + 32'(order[k]));
      else passed++;
      if (k == 4) bus.req_valid = '0;
      step();
      total++;
      if (bus.req_ack !== 4'b0000 || bus.push_out !== 1'b0)
        $display("[TB] FAIL rr_gap%0d got ack=%b push=%b want 0", k, bus.req_ack, bus.push_out);
      else passed++;
    end
  endtask

  task automatic test_write();
    bus.req_addr[64 +: 32]  = 32'h10;
    bus.req_wdata[64 +: 32] = 32'hA5A5_A5A5;
    bus.req_write = 4'b0100;
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    total++;
    if (bus.req_ack !== 4'b0100 || bus.push_out !== 1'b1 || bus.fifo_write_out !== 1'b1 ||
        bus.push_addr_out !== 32'h10 || bus.push_wdata_out !== 32'hA5A5_A5A5)
      $display("[TB] FAIL write_push got ack=%b push=%b wr=%b addr=%h wdata=%h want 0100/1/1/10/a5a5a5a5",
               bus.req_ack, bus.push_out, bus.fifo_write_out, bus.push_addr_out, bus.push_wdata_out);
    else passed++;
    step();
  endtask

  task automatic test_read();
    bus.req_write = 4'b1000;
    bus.req_valid = 4'b0010;
    step();
    total++;
    if (bus.req_ack !== 4'b0010 || bus.push_out !== 1'b1 || bus.fifo_write_out !== 1'b0 ||
        bus.push_addr_out !== 32'h101)
      $display("[TB] FAIL read_push got ack=%b push=%b wr=%b addr=%h want 0010/1/0/101",
               bus.req_ack, bus.push_out, bus.fifo_write_out, bus.push_addr_out);
    else passed++;
    bus.req_valid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (bus.req_ack !== 4'b0000 || bus.push_out !== 1'b0 || bus.req_rdata_ack !== 4'b0000)
        $display("[TB] FAIL read_block%0d got ack=%b push=%b rack=%b want 0",
                 c, bus.req_ack, bus.push_out, bus.req_rdata_ack);
      else passed++;
    end
    bus.rdata_in = 32'h1234_5678;
    bus.rdata_valid_in = 1'b1;
    step();
    bus.rdata_valid_in = 1'b0;
    total++;
    if (bus.req_rdata !== 32'h1234_5678 || bus.req_rdata_ack !== 4'b0010 || bus.req_slverr !== 4'b0000)
      $display("[TB] FAIL read_return got rdata=%h rack=%b err=%b want 12345678/0010/0000",
               bus.req_rdata, bus.req_rdata_ack, bus.req_slverr);
    else passed++;
    step();
    bus.req_valid = '0;
    total++;
    if (bus.req_ack !== 4'b1000 || bus.push_out !== 1'b1 || bus.req_rdata_ack !== 4'b0000)
      $display("[TB] FAIL read_next_grant got ack=%b push=%b rack=%b want 1000/1/0000",
               bus.req_ack, bus.push_out, bus.req_rdata_ack);
    else passed++;
    step();
  endtask

  task automatic test_full();
    bus.full_i = 1'b1;
    bus.req_write = 4'b0001;
    bus.req_valid = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      step();
      total++;
      if (bus.req_ack !== 4'b0000 || bus.push_out !== 1'b0)
        $display("[TB] FAIL full_stall%0d got ack=%b push=%b want 0", c, bus.req_ack, bus.push_out);
      else passed++;
    end
    bus.full_i = 1'b0;
    step();
    bus.req_valid = '0;
    total++;
    if (bus.req_ack !== 4'b0001 || bus.push_out !== 1'b1)
      $display("[TB] FAIL full_release got ack=%b push=%b want 0001/1", bus.req_ack, bus.push_out);
    else passed++;
    step();
  endtask

  task automatic test_reset_in_wait();
    bus.req_write = 4'b0000;
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    total++;
    if (bus.req_ack !== 4'b0100)
      $display("[TB] FAIL rstwait_grant got ack=%b want 0100", bus.req_ack);
    else passed++;
    step();
    step();
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    bus.rdata_in = 32'hDEAD_BEEF;
    bus.rdata_valid_in = 1'b1;
    step();
    bus.rdata_valid_in = 1'b0;
    total++;
    if (bus.req_rdata_ack !== 4'b0000 || bus.req_rdata !== 32'd0)
      $display("[TB] FAIL rstwait_late_data got rack=%b rdata=%h want 0000/0", bus.req_rdata_ack, bus.req_rdata);
    else passed++;
    bus.req_write = 4'b1111;
    bus.req_valid = 4'b1111;
    step();
    bus.req_valid = '0;
    total++;
    if (bus.req_ack !== 4'b0001)
      $display("[TB] FAIL rstwait_regrant got ack=%b want 0001", bus.req_ack);
    else passed++;
    step();
  endtask

`ifdef RR_TIMEOUT_EN
  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      bus.req_write = 4'b0000;
      bus.req_valid = 4'b0001;
      step();
      bus.req_valid = '0;
      total++;
      if (bus.req_ack !== 4'b0001)
        $display("[TB] FAIL timeout%0d_grant got ack=%b want 0001", pass, bus.req_ack);
      else passed++;
      repeat (256) step();
      total++;
      if (bus.req_rdata_ack !== 4'b0000)
        $display("[TB] FAIL timeout%0d_early got rack=%b want 0000", pass, bus.req_rdata_ack);
      else passed++;
      if (pass == 1) begin
        bus.rdata_in = 32'hCAFE_0001;
        bus.rdata_valid_in = 1'b1;
      end
      step();
      bus.rdata_valid_in = 1'b0;
      total++;
      if (pass == 0 && (bus.req_rdata_ack !== 4'b0001 || bus.req_slverr !== 4'b0001 || bus.req_rdata !== 32'd0))
        $display("[TB] FAIL timeout0_fire got rack=%b err=%b rdata=%h want 0001/0001/0",
                 bus.req_rdata_ack, bus.req_slverr, bus.req_rdata);
      else if (pass == 1 && (bus.req_rdata_ack !== 4'b0001 || bus.req_slverr !== 4'b0000 ||
                             bus.req_rdata !== 32'hCAFE_0001))
        $display("[TB] FAIL timeout1_data_wins got rack=%b err=%b rdata=%h want 0001/0000/cafe0001",
                 bus.req_rdata_ack, bus.req_slverr, bus.req_rdata);
      else passed++;
      step();
    end
  endtask
`endif

  initial begin
    $display("[TB] starting rr_fifo_arbiter bench");
    test_reset();
    test_round_robin();
    test_write();
    test_read();
    test_full();
    test_reset_in_wait();
`ifdef RR_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
